// File: rtl/membuf_q_pkg.sv
// membuf_q_pkg: descriptor encodings, tracker entry type and bus-lane helpers shared by membuf_q.
package membuf_q_pkg;
    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b10;
    localparam int P_ST = 0;
    localparam int P_W  = 1;
    localparam int P_U  = 3;
    localparam int P_RD = 4;
    typedef struct packed {
        logic       st;
        logic [1:0] w;
        logic       u;
        logic [4:0] rd;
        logic [1:0] lo;
    } trk_t;
    function automatic bit legal_cfg(int depth, int outst, int lanes);
        return depth >= 2 && depth >= lanes && (depth & (depth - 1)) == 0 && outst >= 1 && outst <= 4;
    endfunction
    function automatic logic [3:0] be_of(logic [1:0] w, logic [1:0] lo);
        return w == W_BYTE ? 4'b0001 << lo : w == W_HALF ? 4'b0011 << {lo[1], 1'b0} : 4'b1111;
    endfunction
    function automatic logic [31:0] rep_of(logic [31:0] d, logic [1:0] w);
        return w == W_BYTE ? {4{d[7:0]}} : w == W_HALF ? {2{d[15:0]}} : d;
    endfunction
    function automatic logic [31:0] lane_ext(logic [31:0] d, logic [1:0] w, logic u, logic [1:0] lo);
        logic [31:0] s;
        s = d >> {lo, 3'b000};
        return w == W_BYTE ? {{24{~u & s[7]}}, s[7:0]} : w == W_HALF ? {{16{~u & s[15]}}, s[15:0]} : s;
    endfunction
endpackage

// File: rtl/membuf_q_trk.sv
// membuf_trk: OUTST-deep FIFO of issued-op descriptors awaiting in-order bus responses.
module membuf_trk
    import membuf_q_pkg::*;
#(
    parameter int OUTST = 2,
    localparam int PW = OUTST > 1 ? $clog2(OUTST) : 1,
    localparam int CW = $clog2(OUTST + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic          i_pop,
    input  trk_t          i_din,
    output trk_t          o_dout,
    output logic [CW-1:0] o_cnt
);
    trk_t          r_mem [OUTST];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [CW-1:0] r_cnt;
    // OUTST need not be a power of two, so wrap explicitly
    function automatic logic [PW-1:0] inc(logic [PW-1:0] p);
        return p == PW'(OUTST - 1) ? '0 : p + PW'(1);
    endfunction
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_din;
                r_wr        <= inc(r_wr);
            end
            if (i_pop) r_rd <= inc(r_rd);
            r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
        end
    end
    assign o_dout = r_mem[r_rd];
    assign o_cnt  = r_cnt;
endmodule

// File: rtl/membuf_q.sv
// membuf_q: in-order load/store queue compacting lane memory ops onto a pipelined data bus
// and returning aligned, extended load data to the register-file write port.
module membuf_q
    import membuf_q_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int EXEC_LEN = 4,
    parameter int DEPTH    = 8,
    parameter int OUTST    = 2,
    parameter int PARA     = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [EXEC_LEN-1:0]      mem_vld,
    input  logic [EXEC_LEN*PARA-1:0] mem_para,
    input  logic [EXEC_LEN*XLEN-1:0] mem_addr,
    input  logic [EXEC_LEN*XLEN-1:0] mem_wdata,
    output logic                     mem_ready,
    output logic                     mem_release,
    output logic                     mem_ovf,
    output logic [4:0]               mem_sel,
    output logic [XLEN-1:0]          mem_data,
    output logic                     dmem_req,
    input  logic                     dmem_ready,
    output logic                     dmem_cmd,
    output logic [XLEN/8-1:0]        dmem_be,
    output logic [XLEN-1:0]          dmem_addr,
    output logic [XLEN-1:0]          dmem_wdata,
    input  logic                     dmem_resp,
    input  logic [XLEN-1:0]          dmem_rdata
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(OUTST + 1);
    localparam int LW = EXEC_LEN > 1 ? $clog2(EXEC_LEN) : 1;
    typedef struct packed {
        logic [PARA-1:0] para;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } op_t;
    if (!legal_cfg(DEPTH, OUTST, EXEC_LEN) || XLEN != 32 || PARA != 9) begin : g_bad
        $error("membuf_q: illegal configuration");
    end
    op_t           r_q [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [AW:0]   r_count;
    logic          r_ovf;
    op_t           w_lane [EXEC_LEN];
    logic [AW:0]   w_off [EXEC_LEN];
    logic [AW:0]   w_nen;
    logic [EXEC_LEN-1:0] w_en;
    logic [LW-1:0] w_byp_lane;
    logic          w_byp;
    logic          w_empty;
    logic          w_hvld;
    logic          w_issue;
    logic          w_resp_ok;
    op_t           w_hop;
    trk_t          w_tin;
    trk_t          w_trk;
    logic [CW-1:0] w_infl;
    always_comb begin
        w_byp      = 1'b0;
        w_byp_lane = '0;
        for (int l = EXEC_LEN - 1; l >= 0; l--) begin
            w_lane[l] = '{para: mem_para[l*PARA +: PARA], addr: mem_addr[l*XLEN +: XLEN], wdata: mem_wdata[l*XLEN +: XLEN]};
            if (mem_vld[l]) begin
                w_byp      = 1'b1;
                w_byp_lane = LW'(l);
            end
        end
    end
    assign w_empty     = r_count == '0;
    assign w_hop       = w_empty ? w_lane[w_byp_lane] : r_q[r_head];
    assign w_hvld      = ~rst & (~w_empty | w_byp);
    assign mem_ready   = r_count <= (AW+1)'(DEPTH - EXEC_LEN);
    assign dmem_req    = w_hvld & ((w_infl < CW'(OUTST)) | dmem_resp);
    assign w_issue     = dmem_req & dmem_ready;
    assign mem_release = w_issue;
    assign mem_ovf     = r_ovf;
    // a lane bypassed straight to the bus is not also written into the queue
    always_comb begin
        w_nen = '0;
        for (int l = 0; l < EXEC_LEN; l++) begin
            w_en[l]  = mem_vld[l] & mem_ready & ~(w_empty & w_issue & (w_byp_lane == LW'(l)));
            w_off[l] = w_nen;
            w_nen    = w_nen + (AW+1)'(w_en[l]);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            for (int l = 0; l < EXEC_LEN; l++)
                if (w_en[l]) r_q[r_tail + w_off[l][AW-1:0]] <= w_lane[l];
            if (w_issue && !w_empty) r_head <= r_head + 1'b1;
            r_tail  <= r_tail + w_nen[AW-1:0];
            r_count <= r_count + w_nen - (AW+1)'(w_issue & ~w_empty);
            r_ovf   <= r_ovf | (|mem_vld & ~mem_ready);
        end
    end
    assign dmem_cmd   = w_hop.para[P_ST];
    assign dmem_be    = w_hvld ? be_of(w_hop.para[P_W +: 2], w_hop.addr[1:0]) : '0;
    assign dmem_addr  = {w_hop.addr[XLEN-1:2], 2'b00};
    assign dmem_wdata = rep_of(w_hop.wdata, w_hop.para[P_W +: 2]);
    assign w_tin = '{st: w_hop.para[P_ST], w: w_hop.para[P_W +: 2], u: w_hop.para[P_U],
                     rd: w_hop.para[P_RD +: 5], lo: w_hop.addr[1:0]};
    membuf_trk #(.OUTST(OUTST)) u_trk (
        .clk    (clk),
        .rst    (rst),
        .i_push (w_issue),
        .i_pop  (w_resp_ok),
        .i_din  (w_tin),
        .o_dout (w_trk),
        .o_cnt  (w_infl)
    );
    // responses with nothing outstanding are stray and must not disturb state
    assign w_resp_ok = ~rst & dmem_resp & (w_infl != '0);
    assign mem_sel   = w_resp_ok & ~w_trk.st ? w_trk.rd : 5'd0;
    assign mem_data  = mem_sel != 5'd0 ? lane_ext(dmem_rdata, w_trk.w, w_trk.u, w_trk.lo) : '0;
endmodule
